// File: rtl/serializer_pkg.sv
// Shared types and limits for the bit-stream serializer.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int unsigned SER_MAX_WIDTH = 32;

    // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int unsigned ser_cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-word skid register for the serializer; present only when SERIALIZER_SKID_EN is defined.
`ifdef SERIALIZER_SKID_EN
module ser_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic             vld
);

    // A simultaneous push and pop keeps the entry occupied with the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else begin
            if (push) begin
                data <= push_data;
            end
            if (push) begin
                vld <= 1'b1;
            end else if (pop) begin
                vld <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bits out.
// Define SERIALIZER_SKID_EN to add a one-word holding register that accepts while shifting.
module bit_stream_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CNT_W = ser_cnt_width(WIDTH);

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SHIFT) && (bit_cnt == '0);
    assign accept   = in_valid && in_ready;

`ifdef SERIALIZER_SKID_EN
    logic             hold_vld;
    logic             hold_push;
    logic             hold_pop;
    logic [WIDTH-1:0] hold_data;

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .push      (hold_push),
        .pop       (hold_pop),
        .push_data (in_data),
        .data      (hold_data),
        .vld       (hold_vld)
    );

    assign in_ready = !hold_vld;
`else
    assign in_ready = (state == IDLE) || last_bit;
`endif

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
`ifdef SERIALIZER_SKID_EN
        hold_push = 1'b0;
        hold_pop  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = in_data;
                    cnt_nxt   = CNT_W'(WIDTH - 1);
                end
            end
            SHIFT: begin
                shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                if (bit_cnt != '0) begin
                    cnt_nxt = bit_cnt - CNT_W'(1);
`ifdef SERIALIZER_SKID_EN
                    hold_push = accept;
`endif
                end else begin
`ifdef SERIALIZER_SKID_EN
                    // The held word always goes out before any newly offered one.
                    if (hold_vld) begin
                        shreg_nxt = hold_data;
                        cnt_nxt   = CNT_W'(WIDTH - 1);
                        hold_pop  = 1'b1;
                        hold_push = accept;
                    end else if (accept) begin
                        shreg_nxt = in_data;
                        cnt_nxt   = CNT_W'(WIDTH - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    if (accept) begin
                        shreg_nxt = in_data;
                        cnt_nxt   = CNT_W'(WIDTH - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // Outputs depend only on registered state, never on the inputs.
    assign dout       = (state == SHIFT) ? shreg[WIDTH-1] : IDLE_BIT;
    assign dout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign word_done  = last_bit;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench for bit_stream_serializer: words accepted become expected bit queues,
// a negedge monitor pops and compares every cycle.
module tb_bit_stream_serializer;

    localparam int unsigned WIDTH    = 4;
    localparam logic        IDLE_BIT = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             word_done;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    bit log_q[$];

    bit_stream_serializer #(
        .WIDTH    (WIDTH),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted word becomes WIDTH bits, MSB first; bit1 of an entry marks the LSB.
    task automatic expect_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exp_q.push_back(int'(w[i]) | ((i == 0) ? 2 : 0));
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d, output bit acc);
        @(negedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        #3;
        acc = v && (in_ready === 1'b1) && !rst;
        if (acc) expect_word(d);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input bit jitter);
        bit               acc;
        logic [WIDTH-1:0] cur;
        acc = 1'b0;
        cur = d;
        for (int n = 0; n < 3 * WIDTH && !acc; n++) begin
            drive_cycle(1'b1, cur, acc);
            if (!acc && jitter) cur = WIDTH'($urandom);
        end
        check("send_timeout", int'(acc), 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, WIDTH'($urandom), acc);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int log_val();
        int v;
        v = 0;
        foreach (log_q[i]) v = (v << 1) | int'(log_q[i]);
        return v;
    endfunction

    // Monitor: the model's pending bit count decides valid/busy/ready; the head entry is the due bit.
    initial begin
        int r;
        int e;
        forever begin
            @(negedge clk);
            r = exp_q.size();
            if (rst) begin
                check("rst_dout", int'(dout), int'(IDLE_BIT));
                check("rst_dout_valid", int'(dout_valid), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_word_done", int'(word_done), 0);
                check("rst_in_ready", int'(in_ready), 1);
            end else begin
                check("dout_valid", int'(dout_valid), int'(r > 0));
                check("busy", int'(busy), int'(r > 0));
`ifdef SERIALIZER_SKID_EN
                check("in_ready", int'(in_ready), int'(r <= int'(WIDTH)));
`else
                check("in_ready", int'(in_ready), int'(r <= 1));
`endif
                if (r > 0) begin
                    e = exp_q.pop_front();
                    check("dout", int'(dout), e & 1);
                    check("word_done", int'(word_done), (e >> 1) & 1);
                    log_q.push_back(dout);
                end else begin
                    check("idle_dout", int'(dout), int'(IDLE_BIT));
                    check("idle_word_done", int'(word_done), 0);
                end
            end
        end
    end

    initial begin
        bit               acc;
        logic [WIDTH-1:0] d;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single word, then back to idle.
        log_q.delete();
        send_word(4'b1011, 1'b0);
        idle(6);
        check("single_len", log_q.size(), 4);
        check("single_bits", log_val(), 'b1011);

        // Two words with valid held high form one gapless stream.
        log_q.delete();
        send_word(4'b1101, 1'b0);
        send_word(4'b0110, 1'b0);
        idle(10);
        check("pair_len", log_q.size(), 8);
        check("pair_bits", log_val(), 'b1101_0110);

        // Valid held while shifting, with in_data wandering until the accept.
        send_word(4'b1001, 1'b1);
        send_word(WIDTH'($urandom), 1'b1);
        send_word(WIDTH'($urandom), 1'b1);
        idle(3 * WIDTH);

        // Reset in the middle of a word discards it; the next word starts from its MSB.
        send_word(4'b1001, 1'b0);
        idle(1);
        pulse_reset(2);
        log_q.delete();
        send_word(4'b0111, 1'b0);
        idle(6);
        check("post_rst_len", log_q.size(), 4);
        check("post_rst_bits", log_val(), 'b0111);

        // Three words offered back to back: 12 contiguous bits.
        log_q.delete();
        send_word(4'b1010, 1'b0);
        send_word(4'b0011, 1'b0);
        send_word(4'b1110, 1'b0);
        idle(16);
        check("triple_len", log_q.size(), 12);
        check("triple_bits", log_val(), 'b1010_0011_1110);

        // Random traffic with valid dropping at will.
        for (int i = 0; i < 300; i++) begin
            d = WIDTH'($urandom);
            drive_cycle(($urandom_range(0, 3) != 0), d, acc);
        end
        idle(3 * WIDTH + 4);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
